gray_monitor: RTL and testbench

- Downstream consumer of the 3-bit Gray counter; samples its Gray code and sticky overflow flag every clock.
- Decodes the Gray code to binary and checks that every change is a legal +1 Gray step.
- Emits a one-cycle step pulse, counts completed laps (wraps through 0) and latches a sticky fault on any illegal transition.
- Feeds status/debug logic that must trust the counter's sequence.

---
 rtl/gray_monitor.sv | 147 ++++++++++++++
 tb/tb_gray_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_monitor.sv
// Checks a Gray-coded counter stream: decodes to binary, flags illegal transitions,
// pulses on each legal +1 step and counts completed laps.
module gray_monitor #(
    parameter int WIDTH = 3,
    parameter int LAP_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic [WIDTH-1:0] Gray,
    input  logic             OvfIn,
    output logic [WIDTH-1:0] Bin,
    output logic             Step,
    output logic [LAP_W-1:0] Lap,
    output logic             LapWrap,
    output logic             OvfRise,
    output logic             Err,
    output logic [1:0]       ErrCode
);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_JUMP = 2'b01;
    localparam logic [1:0] CODE_BACK = 2'b10;
    localparam logic [1:0] CODE_OVF  = 2'b11;

    localparam logic [WIDTH-1:0] MAX_CODE = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             ovf_q;
    logic             step_q, step_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             lapwrap_q, lapwrap_d;
    logic             ovfrise_q, ovfrise_d;
    logic             err_q, err_d;
    logic [1:0]       errcode_q, errcode_d;

    logic [WIDTH-1:0] delta;
    logic             lap_evt;
    logic             step_err;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // bin_q always equals the decode of the previously sampled Gray code
    always_comb begin
        bin_d     = gray2bin(Gray);
        delta     = bin_d - bin_q;
        state_d   = state_q;
        step_d    = 1'b0;
        lap_d     = lap_q;
        lapwrap_d = lapwrap_q;
        ovfrise_d = OvfIn & ~ovf_q;
        err_d     = err_q;
        errcode_d = errcode_q;
        lap_evt   = 1'b0;
        step_err  = 1'b0;

        case (state_q)
            SYNC: begin
                state_d = TRACK;
            end
            TRACK: begin
                if (delta == WIDTH'(1)) begin
                    step_d = 1'b1;
                    if (bin_q == MAX_CODE && bin_d == '0) begin
                        lap_evt = 1'b1;
                        lap_d   = lap_q + LAP_W'(1);
                        if (&lap_q) begin
                            lapwrap_d = 1'b1;
                        end
                    end
                end else if (delta == MAX_CODE) begin
                    step_err  = 1'b1;
                    err_d     = 1'b1;
                    errcode_d = CODE_BACK;
                    state_d   = FAULT;
                end else if (delta != '0) begin
                    step_err  = 1'b1;
                    err_d     = 1'b1;
                    errcode_d = CODE_JUMP;
                    state_d   = FAULT;
                end
                // A step fault on the same edge takes priority over the overflow cause
                if (ovfrise_d && !lap_evt && !step_err) begin
                    err_d     = 1'b1;
                    errcode_d = CODE_OVF;
                    state_d   = FAULT;
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= SYNC;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            step_q    <= 1'b0;
            lap_q     <= '0;
            lapwrap_q <= 1'b0;
            ovfrise_q <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= CODE_NONE;
        end else if (Clr) begin
            state_q   <= SYNC;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            step_q    <= 1'b0;
            lap_q     <= '0;
            lapwrap_q <= 1'b0;
            ovfrise_q <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= CODE_NONE;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            ovf_q     <= OvfIn;
            step_q    <= step_d;
            lap_q     <= lap_d;
            lapwrap_q <= lapwrap_d;
            ovfrise_q <= ovfrise_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
        end
    end

    assign Bin     = bin_q;
    assign Step    = step_q;
    assign Lap     = lap_q;
    assign LapWrap = lapwrap_q;
    assign OvfRise = ovfrise_q;
    assign Err     = err_q;
    assign ErrCode = errcode_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: a behavioural model predicts each cycle's outputs,
// a separate monitor process compares them one cycle later.
module tb_gray_monitor;

    localparam int WIDTH = 3;
    localparam int LAP_W = 2;
    localparam int NCODE = 1 << WIDTH;
    localparam int NLAP  = 1 << LAP_W;

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic             step;
        logic [LAP_W-1:0] lap;
        logic             lapwrap;
        logic             rise;
        logic             err;
        logic [1:0]       code;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Clr = 1'b0;
    logic [WIDTH-1:0] Gray = '0;
    logic             OvfIn = 1'b0;
    logic [WIDTH-1:0] Bin;
    logic             Step;
    logic [LAP_W-1:0] Lap;
    logic             LapWrap;
    logic             OvfRise;
    logic             Err;
    logic [1:0]       ErrCode;

    gray_monitor #(.WIDTH(WIDTH), .LAP_W(LAP_W)) dut (
        .Clk(Clk), .Reset(Reset), .Clr(Clr), .Gray(Gray), .OvfIn(OvfIn),
        .Bin(Bin), .Step(Step), .Lap(Lap), .LapWrap(LapWrap),
        .OvfRise(OvfRise), .Err(Err), .ErrCode(ErrCode)
    );

    always #5 Clk = ~Clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    // Behavioural model state
    bit   m_have_base, m_faulted, m_prev_ovf, m_lapwrap;
    int   m_val, m_lap, m_code;

    function automatic int gray_index(input logic [WIDTH-1:0] g);
        for (int k = 0; k < NCODE; k++) begin
            if (WIDTH'(k ^ (k >> 1)) == g) return k;
        end
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] to_gray(input int k);
        int m;
        m = k % NCODE;
        return WIDTH'(m ^ (m >> 1));
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.bin = Bin; o.step = Step; o.lap = Lap; o.lapwrap = LapWrap;
        o.rise = OvfRise; o.err = Err; o.code = ErrCode;
        return o;
    endfunction

    task automatic model_clear();
        m_have_base = 0; m_faulted = 0; m_prev_ovf = 0; m_lapwrap = 0;
        m_val = 0; m_lap = 0; m_code = 0;
    endtask

    // Predicts the outputs visible after the coming rising edge
    task automatic model_edge(input logic [WIDTH-1:0] g, input logic ovf,
                              input logic clr, input logic rst, output exp_t e);
        int v, d;
        bit step, rise, lap_event;
        step = 0; rise = 0; lap_event = 0;
        if (rst || clr) begin
            model_clear();
        end else begin
            v = gray_index(g);
            rise = ovf && !m_prev_ovf;
            if (!m_have_base) begin
                m_have_base = 1;
            end else if (!m_faulted) begin
                d = (v - m_val + NCODE) % NCODE;
                if (d == 1) begin
                    step = 1;
                    if (m_val == NCODE - 1 && v == 0) begin
                        lap_event = 1;
                        if (m_lap == NLAP - 1) m_lapwrap = 1;
                        m_lap = (m_lap + 1) % NLAP;
                    end
                end else if (d == NCODE - 1) begin
                    m_faulted = 1; m_code = 2;
                end else if (d != 0) begin
                    m_faulted = 1; m_code = 1;
                end
                if (!m_faulted && rise && !lap_event) begin
                    m_faulted = 1; m_code = 3;
                end
            end
            m_val = v;
            m_prev_ovf = ovf;
        end
        e.bin = WIDTH'(m_val); e.step = step; e.lap = LAP_W'(m_lap);
        e.lapwrap = m_lapwrap; e.rise = rise; e.err = m_faulted; e.code = 2'(m_code);
    endtask

    task automatic drive(input logic [WIDTH-1:0] g, input logic ovf,
                         input logic clr, input logic rst);
        exp_t e;
        @(negedge Clk);
        Reset = rst; Clr = clr; Gray = g; OvfIn = ovf;
        model_edge(g, ovf, clr, rst, e);
        sb.push_back(e);
    endtask

    task automatic step_to(input int k, input logic ovf);
        drive(to_gray(k), ovf, 1'b0, 1'b0);
    endtask

    task automatic clear_cycle();
        drive('0, 1'b0, 1'b1, 1'b0);
    endtask

    // Asserts Reset between edges and checks that outputs drop without a clock
    task automatic async_reset();
        exp_t e, o;
        @(negedge Clk);
        #2;
        Reset = 1'b1; Clr = 1'b0; Gray = '0; OvfIn = 1'b0;
        #1;
        o = observed();
        n_cmp++;
        if (o !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h, expected %h", o, exp_t'(0));
        end
        model_edge('0, 1'b0, 1'b0, 1'b1, e);
        sb.push_back(e);
    endtask

    // Monitor: every edge after stimulus begins has exactly one predicted entry
    initial begin
        exp_t e, o;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                o = observed();
                cyc_no++;
                n_cmp++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got bin=%0d step=%0b lap=%0d wrap=%0b rise=%0b err=%0b code=%0d, expected bin=%0d step=%0b lap=%0d wrap=%0b rise=%0b err=%0b code=%0d",
                             cyc_no, o.bin, o.step, o.lap, o.lapwrap, o.rise, o.err, o.code,
                             e.bin, e.step, e.lap, e.lapwrap, e.rise, e.err, e.code);
                end
            end
        end
    end

    initial begin
        int k, r;
        logic ovf;
        model_clear();

        drive('0, 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b1);

        // Full lap, overflow rising together with the wrap to 000
        step_to(0, 1'b0);
        for (int i = 1; i < NCODE; i++) step_to(i, 1'b0);
        step_to(0, 1'b1);

        // Hold at 011 for several cycles
        step_to(1, 1'b1);
        for (int i = 0; i < 5; i++) step_to(2, 1'b1);
        step_to(3, 1'b0);
        clear_cycle();

        // Non-adjacent jump 001 -> 110, then legal steps stay frozen
        step_to(0, 1'b0);
        step_to(1, 1'b0);
        step_to(4, 1'b0);
        for (int i = 5; i <= 8; i++) step_to(i, 1'b0);
        clear_cycle();

        // Backward 011 -> 001, later overflow keeps the first cause
        step_to(0, 1'b0);
        step_to(1, 1'b0);
        step_to(2, 1'b0);
        step_to(1, 1'b0);
        step_to(1, 1'b1);
        step_to(1, 1'b0);
        clear_cycle();

        // Overflow rising on a non-lap step 010 -> 110
        step_to(0, 1'b0);
        for (int i = 1; i <= 3; i++) step_to(i, 1'b0);
        step_to(4, 1'b1);
        step_to(4, 1'b1);
        clear_cycle();

        // Four laps wrap the 2-bit lap counter, then reset mid-lap
        step_to(0, 1'b0);
        for (int i = 1; i <= 4 * NCODE + 3; i++) step_to(i, 1'b0);
        async_reset();
        step_to(0, 1'b0);
        step_to(1, 1'b0);
        step_to(2, 1'b0);

        // Randomised traffic: mostly legal steps and holds, occasional faults
        k = 2; ovf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) ovf = ~ovf;
            if (i % 97 == 50) begin
                async_reset();
                k = 0; ovf = 1'b0;
            end else if (r < 3) begin
                clear_cycle();
                k = 0; ovf = 1'b0;
            end else if (r < 60) begin
                k = (k + 1) % NCODE;
                step_to(k, ovf);
            end else if (r < 88) begin
                step_to(k, ovf);
            end else begin
                k = $urandom_range(0, NCODE - 1);
                step_to(k, ovf);
            end
        end

        repeat (2) @(posedge Clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
